// File: rtl/fetch_sequencer_if.sv
// =====================================================================
// Module   : fetch_sequencer_if
// Brief    : Issue/decode handshake between fetch_sequencer and control.
// Revision : 1.0
// =====================================================================
`default_nettype none

interface fetch_sequencer_if;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        jump;
    logic        is_ret;
    logic        br_taken;

    modport master (
        output instr, opcode, instr_valid,
        input  instr_ready, branch, jump, is_ret, br_taken
    );

    modport slave (
        input  instr, opcode, instr_valid,
        output instr_ready, branch, jump, is_ret, br_taken
    );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// =====================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and instruction issue with a circular return-address
//            stack. Define FETCH_PERF_EN to add issue/redirect counters.
// Revision : 1.0
// =====================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int         PC_W      = 8,
    parameter int         RAS_DEPTH = 4,
    parameter logic [4:0] HALT_OP   = 5'h1F
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            start,
    output logic [PC_W-1:0]      imem_addr,
    input  wire logic [31:0]     imem_rdata,
    output logic [PC_W-1:0]      pc_out,
    output logic                 ras_err,
    fetch_sequencer_if.master    dec
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          perf_issued,
    output logic [15:0]          perf_redirects
`endif
);

    localparam int                c_PTR_W = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt, w_pc_inc;
    logic [PC_W-1:0]     w_target, w_offset;
    logic [PC_W-1:0]     r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0]  r_ptr, w_ptr_dec;
    logic [c_PTR_W:0]    r_cnt;
    logic                r_err;
    logic                w_accept, w_is_halt, w_push, w_pop, w_err_set;

    assign w_accept  = (r_state == S_RUN) && dec.instr_ready;
    assign w_is_halt = (imem_rdata[31:27] == HALT_OP);
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_ptr_dec = r_ptr - c_PTR_W'(1);

    // Jump target is imm zero-extended, branch offset is imm sign-extended, both to PC_W.
    generate
        if (PC_W <= 12) begin : g_narrow_pc
            assign w_target = imem_rdata[PC_W-1:0];
            assign w_offset = imem_rdata[PC_W-1:0];
        end else begin : g_wide_pc
            assign w_target = {{(PC_W-12){1'b0}}, imem_rdata[11:0]};
            assign w_offset = {{(PC_W-12){imem_rdata[11]}}, imem_rdata[11:0]};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_accept) begin
                    if (w_is_halt) begin
                        w_state_nxt = S_HALT;
                        w_pc_nxt    = w_pc_inc;
                    end else if (dec.is_ret) begin
                        if (r_cnt == '0) begin
                            w_err_set = 1'b1;
                            w_pc_nxt  = w_pc_inc;
                        end else begin
                            w_pop    = 1'b1;
                            w_pc_nxt = r_ras[w_ptr_dec];
                        end
                    end else if (dec.jump) begin
                        w_push    = 1'b1;
                        w_err_set = (r_cnt == c_FULL);
                        w_pc_nxt  = w_target;
                    end else if (dec.branch && dec.br_taken) begin
                        w_pc_nxt = w_pc_inc + w_offset;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_err_set) r_err <= 1'b1;
            // A push onto a full stack overwrites the oldest slot; depth stays at full.
            if (w_push) begin
                r_ras[r_ptr] <= w_pc_inc;
                r_ptr        <= r_ptr + c_PTR_W'(1);
                if (r_cnt != c_FULL) r_cnt <= r_cnt + (c_PTR_W+1)'(1);
            end else if (w_pop) begin
                r_ptr <= w_ptr_dec;
                r_cnt <= r_cnt - (c_PTR_W+1)'(1);
            end
        end
    end

    assign imem_addr       = r_pc;
    assign pc_out          = r_pc;
    assign ras_err         = r_err;
    assign dec.instr       = imem_rdata;
    assign dec.opcode      = imem_rdata[31:27];
    assign dec.instr_valid = (r_state == S_RUN);

`ifdef FETCH_PERF_EN
    logic        w_redirect;
    logic [15:0] r_perf_issued, r_perf_redir;

    assign w_redirect = w_accept && !w_is_halt &&
                        (dec.is_ret || dec.jump || (dec.branch && dec.br_taken));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_issued <= '0;
            r_perf_redir  <= '0;
        end else begin
            if (w_accept && (r_perf_issued != 16'hFFFF))
                r_perf_issued <= r_perf_issued + 16'd1;
            if (w_redirect && (r_perf_redir != 16'hFFFF))
                r_perf_redir <= r_perf_redir + 16'd1;
        end
    end

    assign perf_issued    = r_perf_issued;
    assign perf_redirects = r_perf_redir;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// =====================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed and randomized bench for fetch_sequencer against a
//            queue-based reference model of the issue/redirect rules.
// Revision : 1.0
// =====================================================================
`default_nettype none

module tb_fetch_sequencer;
    localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2, OP_JMP = 5'd3,
                           OP_RET = 5'd4, OP_BEQ = 5'd5, OP_HALT = 5'h1F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [7:0]  pc_out;
    logic        ras_err;
    logic [31:0] mem [256];
`ifdef FETCH_PERF_EN
    logic [15:0] perf_issued, perf_redirects;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_pc;
    bit         m_run;
    bit         m_err;
    logic [7:0] m_ras[$];
    int         m_issued, m_redir;

    fetch_sequencer_if bus();

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_W(8), .RAS_DEPTH(4), .HALT_OP(5'h1F)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .ras_err(ras_err), .dec(bus)
`ifdef FETCH_PERF_EN
        , .perf_issued(perf_issued), .perf_redirects(perf_redirects)
`endif
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [11:0] imm);
        return {op, 15'h0, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = mk(OP_NOP, 12'h000);
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_run = 0; m_err = 0; m_ras.delete(); m_issued = 0; m_redir = 0;
    endtask

    task automatic model_step(input bit s, rdy, br, jp, rt, tk);
        logic [31:0] w;
        int off;
        w = mem[m_pc];
        if (!m_run) begin
            if (s) m_run = 1;
        end else if (rdy) begin
            m_issued++;
            if (w[31:27] == OP_HALT) begin
                m_run = 0;
                m_pc  = m_pc + 8'd1;
            end else if (rt) begin
                m_redir++;
                if (m_ras.size() == 0) begin m_err = 1; m_pc = m_pc + 8'd1; end
                else m_pc = m_ras.pop_back();
            end else if (jp) begin
                m_redir++;
                if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_err = 1; end
                m_ras.push_back(m_pc + 8'd1);
                m_pc = w[7:0];
            end else if (br && tk) begin
                m_redir++;
                off  = w[11] ? int'(w[11:0]) - 4096 : int'(w[11:0]);
                m_pc = 8'((int'(m_pc) + 1 + off) & 255);
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic cycle(input bit s, rdy, br, jp, rt, tk);
        start = s; bus.instr_ready = rdy; bus.branch = br;
        bus.jump = jp; bus.is_ret = rt; bus.br_taken = tk;
        model_step(s, rdy, br, jp, rt, tk);
        @(posedge clk); #1;
        start = 0; bus.instr_ready = 0; bus.branch = 0;
        bus.jump = 0; bus.is_ret = 0; bus.br_taken = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; bus.instr_ready = 0; bus.branch = 0;
        bus.jump = 0; bus.is_ret = 0; bus.br_taken = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic run_to(input logic [7:0] target);
        for (int k = 0; k < 300 && m_pc != target; k++) cycle(0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (pc_out !== target) begin
            n_fail++; $display("FAIL run_to: pc_out %h required %h", pc_out, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; bus.instr_ready = 1; bus.branch = 0;
        bus.jump = 0; bus.is_ret = 0; bus.br_taken = 0;
        model_reset();
        #2;
        n_cmp++; if (pc_out !== 8'h00) begin n_fail++; $display("FAIL reset_pc: pc_out %h required 00", pc_out); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: imem_addr %h required 00", imem_addr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %b required 0", bus.instr_valid); end
        n_cmp++; if (ras_err !== 1'b0) begin n_fail++; $display("FAIL reset_raserr: %b required 0", ras_err); end
        @(posedge clk); #1;
        rst_n = 1;
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: valid %b required 0", bus.instr_valid); end
    endtask

    task automatic test_sequential();
        logic [4:0] exp_op [3];
        exp_op = '{OP_ADD, OP_SUB, OP_ADD};
        clear_mem();
        mem[0] = mk(OP_ADD, 12'h001); mem[1] = mk(OP_SUB, 12'h002); mem[2] = mk(OP_ADD, 12'h003);
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (pc_out !== 8'(k) || bus.instr_valid !== 1'b1) begin
                n_fail++; $display("FAIL seq_pc%0d: pc_out %h valid %b required %h/1", k, pc_out, bus.instr_valid, 8'(k));
            end
            n_cmp++;
            if (bus.opcode !== exp_op[k]) begin
                n_fail++; $display("FAIL seq_op%0d: opcode %h required %h", k, bus.opcode, exp_op[k]);
            end
            if (k < 2) cycle(0, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        clear_mem();
        mem[5] = mk(OP_SUB, 12'h5A5);
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        run_to(8'h05);
        held = mem[5];
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 1, 1, 1);
            n_cmp++;
            if (pc_out !== 8'h05 || bus.instr !== held || bus.opcode !== OP_SUB || bus.instr_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall%0d: pc %h instr %h op %h required 05 %h %h", k, pc_out, bus.instr, bus.opcode, held, OP_SUB);
            end
        end
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++; if (pc_out !== 8'h06) begin n_fail++; $display("FAIL stall_release: pc_out %h required 06", pc_out); end
    endtask

    task automatic test_call_return();
        clear_mem();
        mem[8'h10] = mk(OP_JMP, 12'h040);
        mem[8'h40] = mk(OP_RET, 12'h000);
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        run_to(8'h10);
        cycle(0, 1, 0, 1, 0, 0);
        n_cmp++; if (pc_out !== 8'h40) begin n_fail++; $display("FAIL call: pc_out %h required 40", pc_out); end
        cycle(0, 1, 0, 0, 1, 0);
        n_cmp++; if (pc_out !== 8'h11) begin n_fail++; $display("FAIL ret: pc_out %h required 11", pc_out); end
        n_cmp++; if (ras_err !== 1'b0) begin n_fail++; $display("FAIL call_raserr: %b required 0", ras_err); end
    endtask

    task automatic test_branch();
        clear_mem();
        mem[8'h20] = mk(OP_BEQ, 12'hFFE);
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        run_to(8'h20);
        cycle(0, 1, 1, 0, 0, 1);
        n_cmp++; if (pc_out !== 8'h1F) begin n_fail++; $display("FAIL br_taken: pc_out %h required 1f", pc_out); end
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        n_cmp++; if (pc_out !== 8'h21) begin n_fail++; $display("FAIL br_not_taken: pc_out %h required 21", pc_out); end
    endtask

    task automatic test_ras_limits();
        logic [7:0] ret_seq [4];
        ret_seq = '{8'h21, 8'h19, 8'h11, 8'h09};
        clear_mem();
        mem[8'h00] = mk(OP_JMP, 12'h008); mem[8'h08] = mk(OP_JMP, 12'h010);
        mem[8'h10] = mk(OP_JMP, 12'h018); mem[8'h18] = mk(OP_JMP, 12'h020);
        mem[8'h20] = mk(OP_JMP, 12'h030); mem[8'h30] = mk(OP_RET, 12'h000);
        mem[8'h21] = mk(OP_RET, 12'h000); mem[8'h19] = mk(OP_RET, 12'h000);
        mem[8'h11] = mk(OP_RET, 12'h000); mem[8'h09] = mk(OP_BEQ, 12'h026);
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, 1, 0, 0);
        n_cmp++; if (ras_err !== 1'b0 || pc_out !== 8'h20) begin n_fail++; $display("FAIL ras_fill: err %b pc %h required 0/20", ras_err, pc_out); end
        cycle(0, 1, 0, 1, 0, 0);
        n_cmp++; if (ras_err !== 1'b1 || pc_out !== 8'h30) begin n_fail++; $display("FAIL ras_overflow: err %b pc %h required 1/30", ras_err, pc_out); end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 0, 0, 1, 0);
            n_cmp++; if (pc_out !== ret_seq[k]) begin n_fail++; $display("FAIL ras_pop%0d: pc_out %h required %h", k, pc_out, ret_seq[k]); end
        end
        cycle(0, 1, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 1, 0);
        n_cmp++; if (pc_out !== 8'h31 || ras_err !== 1'b1) begin n_fail++; $display("FAIL ras_underflow: pc %h err %b required 31/1", pc_out, ras_err); end
    endtask

    task automatic test_halt_wrap();
        clear_mem();
        mem[8'hFF] = mk(OP_HALT, 12'h000);
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        run_to(8'hFF);
        cycle(1, 0, 0, 0, 0, 0);
        n_cmp++; if (pc_out !== 8'hFF || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL start_in_run: pc %h valid %b required ff/1", pc_out, bus.instr_valid); end
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt: valid %b required 0", bus.instr_valid); end
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold: valid %b required 0", bus.instr_valid); end
        cycle(1, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.instr_valid !== 1'b1 || pc_out !== 8'h00) begin n_fail++; $display("FAIL restart_wrap: valid %b pc %h required 1/00", bus.instr_valid, pc_out); end
    endtask

    task automatic test_reset_mid_run();
        clear_mem();
        do_reset();
        cycle(1, 1, 0, 0, 0, 0);
        run_to(8'h07);
        bus.instr_ready = 1;
        #2; rst_n = 0; #1;
        n_cmp++; if (pc_out !== 8'h00 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: pc %h valid %b required 00/0", pc_out, bus.instr_valid); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        cycle(0, 1, 0, 0, 0, 0);
        n_cmp++; if (pc_out !== 8'h00 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: pc %h valid %b required 00/0", pc_out, bus.instr_valid); end
    endtask

    task automatic test_random();
        bit s, rdy, br, jp, rt, tk;
        int r;
        logic [4:0] op;
        for (int i = 0; i < 256; i++) begin
            op = ($urandom_range(0, 99) < 3) ? OP_HALT : 5'($urandom_range(0, 30));
            mem[i] = {op, 15'($urandom), 12'($urandom)};
        end
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 399) do_reset();
            s   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            br = 0; jp = 0; rt = 0; tk = 0;
            if (m_run && mem[m_pc][31:27] != OP_HALT) begin
                r  = $urandom_range(0, 15);
                jp = (r < 2) || (r == 4);
                rt = (r == 2) || (r == 3) || (r == 4);
                br = (r >= 5) && (r <= 8);
                tk = $urandom_range(0, 1) == 1;
            end
            cycle(s, rdy, br, jp, rt, tk);
            n_cmp++;
            if (pc_out !== m_pc || imem_addr !== m_pc || bus.instr_valid !== m_run || ras_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_state@%0d: pc %h addr %h valid %b err %b required %h %h %b %b",
                         i, pc_out, imem_addr, bus.instr_valid, ras_err, m_pc, m_pc, m_run, m_err);
            end
            if (m_run) begin
                n_cmp++;
                if (bus.instr !== mem[m_pc] || bus.opcode !== mem[m_pc][31:27]) begin
                    n_fail++; $display("FAIL rand_instr@%0d: instr %h op %h required %h", i, bus.instr, bus.opcode, mem[m_pc]);
                end
            end
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if (perf_issued !== 16'(m_issued) || perf_redirects !== 16'(m_redir)) begin
            n_fail++; $display("FAIL perf: issued %0d redir %0d required %0d %0d", perf_issued, perf_redirects, m_issued, m_redir);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; start = 0;
        bus.instr_ready = 0; bus.branch = 0; bus.jump = 0; bus.is_ret = 0; bus.br_taken = 0;
        clear_mem();
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_call_return();
        test_branch();
        test_ras_limits();
        test_halt_wrap();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
